// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared state encoding and default timing constants for the SPI transfer sequencer.
// W_CPU mirrors the CPU word width used by the opcode definitions.
package spi_xfer_ctrl_pkg;

   localparam int unsigned W_CPU = 32;

   localparam int unsigned CS_SETUP_DEF = 2;
   localparam int unsigned CS_HOLD_DEF  = 2;
   localparam int unsigned GAP_DEF      = 3;
   localparam int unsigned TIMEOUT_DEF  = 64;
   localparam int unsigned W_CNT_DEF    = 8;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StSetup = 3'd1,
      StStart = 3'd2,
      StXfer  = 3'd3,
      StHold  = 3'd4,
      StGap   = 3'd5
   } xfer_state_e;

   // Chip select is low from the first setup cycle through the last hold cycle.
   function automatic logic cs_active(input xfer_state_e s);
      return (s == StSetup) || (s == StStart) || (s == StXfer) || (s == StHold);
   endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// CPU-side word handshake of the SPI transfer sequencer.
// master = CPU, slave = sequencer.
interface spi_xfer_ctrl_if
   import spi_xfer_ctrl_pkg::*;
#(
   parameter int unsigned W_Data = W_CPU
);

   logic              tx_valid;
   logic              tx_ready;
   logic [W_Data-1:0] tx_data;
   logic              rx_valid;
   logic              rx_ack;
   logic [W_Data-1:0] rx_data;
   logic              xfer_err;
   logic              err_clr;

   modport master (
      output tx_valid, tx_data, rx_ack, err_clr,
      input  tx_ready, rx_valid, rx_data, xfer_err
   );

   modport slave (
      input  tx_valid, tx_data, rx_ack, err_clr,
      output tx_ready, rx_valid, rx_data, xfer_err
   );

endinterface

// File: rtl/spi_frame_timer.sv
// Loadable down-counter with a zero flag; shared by the setup, hold, gap and
// timeout intervals. Decrement saturates at zero.
module spi_frame_timer #(
   parameter int unsigned W_Cnt = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [W_Cnt-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [W_Cnt-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: accepts a CPU word, frames it with chip select, kicks the
// MOSI/MISO shifters, returns the received word, and enforces timeout and frame gap.
module spi_xfer_ctrl
   import spi_xfer_ctrl_pkg::*;
#(
   parameter int unsigned W_Data   = W_CPU,
   parameter int unsigned CS_SETUP = CS_SETUP_DEF,
   parameter int unsigned CS_HOLD  = CS_HOLD_DEF,
   parameter int unsigned GAP      = GAP_DEF,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
   parameter int unsigned W_Cnt    = W_CNT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   spi_xfer_ctrl_if.slave    cpu,
   output logic              cs_n,
   output logic [W_Data-1:0] tx_word,
   output logic              tx_start,
   output logic              rx_start,
   input  logic              mosi_ready,
   input  logic              miso_ready,
   input  logic [W_Data-1:0] miso_word,
   output logic              busy
);

   xfer_state_e state_q, state_d;

   logic              seen_low_q, seen_low_d;
   logic [W_Data-1:0] tx_word_q, tx_word_d;
   logic [W_Data-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              err_q, err_d;
   logic              tx_ready_q, tx_ready_d;
   logic              cs_n_q, cs_n_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;

   logic              tmr_load;
   logic [W_Cnt-1:0]  tmr_val;
   logic              tmr_dec;
   logic              tmr_zero;
   logic              rx_capture;
   logic              err_set;
   logic              done;

   spi_frame_timer #(
      .W_Cnt (W_Cnt)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Completion needs both shifters to have been seen busy first, so stale
   // ready levels from the previous frame cannot end this one early.
   assign done = seen_low_q && mosi_ready && miso_ready;

   always_comb begin
      state_d    = state_q;
      seen_low_d = seen_low_q;
      tx_word_d  = tx_word_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      tmr_dec    = 1'b0;
      rx_capture = 1'b0;
      err_set    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cpu.tx_valid && tx_ready_q) begin
               tx_word_d = cpu.tx_data;
               tmr_load  = 1'b1;
               tmr_val   = W_Cnt'(CS_SETUP - 1);
               state_d   = StSetup;
            end
         end
         StSetup: begin
            if (tmr_zero) state_d = StStart;
            else          tmr_dec = 1'b1;
         end
         StStart: begin
            seen_low_d = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = W_Cnt'(TIMEOUT - 1);
            state_d    = StXfer;
         end
         StXfer: begin
            tmr_dec = 1'b1;
            if (!mosi_ready && !miso_ready) seen_low_d = 1'b1;
            if (done) begin
               rx_capture = 1'b1;
               tmr_load   = 1'b1;
               tmr_val    = W_Cnt'(CS_HOLD - 1);
               state_d    = StHold;
            end else if (tmr_zero) begin
               err_set  = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = W_Cnt'(CS_HOLD - 1);
               state_d  = StHold;
            end
         end
         StHold: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = W_Cnt'(GAP - 1);
               state_d  = StGap;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         StGap: begin
            if (tmr_zero) state_d = StIdle;
            else          tmr_dec = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // Capture beats a simultaneous ack; error set beats a simultaneous clear.
   always_comb begin
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      if (rx_capture) begin
         rx_valid_d = 1'b1;
         rx_data_d  = miso_word;
      end else if (cpu.rx_ack && rx_valid_q) begin
         rx_valid_d = 1'b0;
      end

      err_d = err_q;
      if (err_set)          err_d = 1'b1;
      else if (cpu.err_clr) err_d = 1'b0;
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      cs_n_d     = !cs_active(state_d);
      start_d    = (state_d == StStart);
      busy_d     = (state_d != StIdle);
      tx_ready_d = (state_d == StIdle) && !rx_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         seen_low_q <= 1'b0;
         tx_word_q  <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         err_q      <= 1'b0;
         tx_ready_q <= 1'b1;
         cs_n_q     <= 1'b1;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         seen_low_q <= seen_low_d;
         tx_word_q  <= tx_word_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         err_q      <= err_d;
         tx_ready_q <= tx_ready_d;
         cs_n_q     <= cs_n_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
      end
   end

   assign cpu.tx_ready = tx_ready_q;
   assign cpu.rx_valid = rx_valid_q;
   assign cpu.rx_data  = rx_data_q;
   assign cpu.xfer_err = err_q;
   assign cs_n         = cs_n_q;
   assign tx_word      = tx_word_q;
   assign tx_start     = start_q;
   assign rx_start     = start_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: loopback shifter model, frame-timing monitor, vector
// table, hand-written corner sequences and a randomized run against a word queue.
module tb_spi_xfer_ctrl;
   import spi_xfer_ctrl_pkg::*;

   localparam int W        = 32;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int GAP      = 3;
   localparam int TIMEOUT  = 64;
   // Loopback shifter holds ready low for W+1 cycles; completion lands on the rise.
   localparam int XFER_LOOP = W + 2;
   localparam int LAT       = CS_SETUP + 1;
   localparam int CS_LOW_OK = CS_SETUP + 1 + XFER_LOOP + CS_HOLD;
   localparam int CS_LOW_TO = CS_SETUP + 1 + TIMEOUT + CS_HOLD;
   localparam int ERR_LAT   = CS_SETUP + 1 + TIMEOUT + 1;

   logic         clk;
   logic         rst;
   logic         cs_n, tx_start, rx_start, busy;
   logic [W-1:0] tx_word, miso_word;
   logic         mosi_ready, miso_ready;

   spi_xfer_ctrl_if #(.W_Data(W)) bus ();

   spi_xfer_ctrl #(
      .W_Data   (W),
      .CS_SETUP (CS_SETUP),
      .CS_HOLD  (CS_HOLD),
      .GAP      (GAP),
      .TIMEOUT  (TIMEOUT),
      .W_Cnt    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu        (bus.slave),
      .cs_n       (cs_n),
      .tx_word    (tx_word),
      .tx_start   (tx_start),
      .rx_start   (rx_start),
      .mosi_ready (mosi_ready),
      .miso_ready (miso_ready),
      .miso_word  (miso_word),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Loopback shifter: MOSI serial line feeds MISO, MSB first.
   logic         sh_busy;
   int           sh_cnt;
   logic [W-1:0] sh_tx, sh_rx;
   bit           stuck = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_busy <= 1'b0;
         sh_cnt  <= 0;
         sh_tx   <= '0;
         sh_rx   <= '0;
      end else if (tx_start) begin
         sh_busy <= 1'b1;
         sh_cnt  <= W;
         sh_tx   <= tx_word;
      end else if (sh_busy && !stuck) begin
         if (sh_cnt > 0) begin
            sh_rx  <= {sh_rx[W-2:0], sh_tx[W-1]};
            sh_tx  <= sh_tx << 1;
            sh_cnt <= sh_cnt - 1;
         end else begin
            sh_busy <= 1'b0;
         end
      end
   end

   assign mosi_ready = !sh_busy;
   assign miso_ready = !sh_busy;
   assign miso_word  = sh_rx;

   // Frame monitor, sampled 1 time unit after each rising edge.
   int cyc = 0, frames_done = 0, n_start = 0, n_rxstart = 0, rxv_hi = 0;
   int cs_fall = 0, cs_rise = 0, cs_low_len = 0, last_gap = 0;
   int start_cyc = -1, rxv_cyc = -1, err_cyc = -1;
   logic cs_prev = 1'b1, rxv_prev = 1'b0, err_prev = 1'b0;
   logic [W-1:0] rx_log[$];

   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         cs_prev  = 1'b1;
         rxv_prev = 1'b0;
         err_prev = 1'b0;
      end else begin
         if (cs_prev && !cs_n) begin
            cs_fall  = cyc;
            last_gap = cyc - cs_rise;
         end
         if (!cs_prev && cs_n) begin
            cs_rise    = cyc;
            cs_low_len = cyc - cs_fall;
            frames_done++;
         end
         if (tx_start) begin
            n_start++;
            start_cyc = cyc;
         end
         if (rx_start) n_rxstart++;
         if (bus.rx_valid) rxv_hi++;
         if (bus.rx_valid && !rxv_prev) begin
            rxv_cyc = cyc;
            rx_log.push_back(bus.rx_data);
         end
         if (bus.xfer_err && !err_prev) err_cyc = cyc;
         cs_prev  = cs_n;
         rxv_prev = bus.rx_valid;
         err_prev = bus.xfer_err;
      end
   end

   int total = 0, bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic check_ge(input string name, input int act, input int min);
      total++;
      if (act < min) begin
         bad++;
         $display("FAIL %s: got %0d want >= %0d", name, act, min);
      end
   endtask

   task automatic send(input logic [W-1:0] w, output int acc);
      acc          = -1;
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      for (int n = 0; n < 400 && acc < 0; n++) begin
         if (bus.tx_ready) acc = cyc;
         else @(negedge clk);
      end
      if (acc < 0) begin
         total++;
         bad++;
         $display("FAIL send_accept: tx_ready never seen for 0x%08h", w);
      end
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_rx(output logic [W-1:0] d);
      bit got = 1'b0;
      d = '0;
      for (int n = 0; n < 400 && !got; n++) begin
         if (bus.rx_valid) begin
            d   = bus.rx_data;
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL wait_rx: rx_valid got 0 want 1 within bound");
      end
   endtask

   task automatic wait_frame(input int f0);
      for (int n = 0; n < 400 && frames_done <= f0; n++) @(negedge clk);
      if (frames_done <= f0) begin
         total++;
         bad++;
         $display("FAIL wait_frame: cs_n rise count got %0d want %0d", frames_done, f0 + 1);
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 400 && busy; n++) @(negedge clk);
      if (busy) begin
         total++;
         bad++;
         $display("FAIL wait_idle: busy got 1 want 0");
      end
   endtask

   task automatic ack();
      bus.rx_ack = 1'b1;
      @(negedge clk);
      bus.rx_ack = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] word;
      logic [W-1:0] exp_rx;
      int           exp_lat;
      int           exp_cs_low;
   } vec_t;

   vec_t         vecs[6];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] d;
   int           acc, acc2, f0, n0, r0, l0;

   initial begin
      vecs[0] = '{32'hA5A5_F00F, 32'hA5A5_F00F, LAT, CS_LOW_OK};
      vecs[1] = '{32'h0000_0000, 32'h0000_0000, LAT, CS_LOW_OK};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, CS_LOW_OK};
      vecs[3] = '{32'h8000_0001, 32'h8000_0001, LAT, CS_LOW_OK};
      vecs[4] = '{32'h1234_5678, 32'h1234_5678, LAT, CS_LOW_OK};
      vecs[5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, LAT, CS_LOW_OK};

      rst          = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      bus.rx_ack   = 1'b0;
      bus.err_clr  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_ready", bus.tx_ready, 1);
      check("rst_cs_n", cs_n, 1);
      check("rst_tx_start", tx_start, 0);
      check("rst_rx_start", rx_start, 0);
      check("rst_rx_valid", bus.rx_valid, 0);
      check("rst_rx_data", bus.rx_data, 0);
      check("rst_xfer_err", bus.xfer_err, 0);
      check("rst_tx_word", tx_word, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Vector table, loopback shifter.
      for (int i = 0; i < 6; i++) begin
         f0 = frames_done;
         n0 = n_start;
         r0 = n_rxstart;
         send(vecs[i].word, acc);
         check("vec_tx_word", tx_word, vecs[i].word);
         wait_rx(d);
         ack();
         wait_frame(f0);
         check("vec_rx_data", d, vecs[i].exp_rx);
         check_int("vec_start_lat", start_cyc - acc, vecs[i].exp_lat);
         check_int("vec_cs_low", cs_low_len, vecs[i].exp_cs_low);
         check_int("vec_hold_after_capture", cs_rise - rxv_cyc, CS_HOLD);
         check_int("vec_tx_start_count", n_start - n0, 1);
         check_int("vec_rx_start_count", n_rxstart - r0, 1);
         wait_idle();
      end

      // Back-to-back with rx_ack held: each capture shows for one cycle despite the ack.
      bus.rx_ack = 1'b1;
      f0 = frames_done;
      r0 = rxv_hi;
      l0 = rx_log.size();
      send(32'h0000_0001, acc);
      send(32'hFFFF_FFFF, acc2);
      check_ge("b2b_refused_during_gap", acc2 - cs_rise, GAP);
      wait_frame(f0 + 1);
      check_ge("b2b_gap", last_gap, GAP);
      check_int("b2b_rx_count", rx_log.size() - l0, 2);
      if (rx_log.size() - l0 == 2) begin
         check("b2b_first", rx_log[l0], 32'h0000_0001);
         check("b2b_second", rx_log[l0+1], 32'hFFFF_FFFF);
      end
      check_int("b2b_rx_valid_cycles", rxv_hi - r0, 2);
      bus.rx_ack = 1'b0;
      wait_idle();

      // Unacknowledged rx word blocks the next frame.
      f0 = frames_done;
      send(32'h0BAD_CAFE, acc);
      wait_frame(f0);
      wait_idle();
      check("bp_tx_ready_blocked", bus.tx_ready, 0);
      check("bp_rx_valid", bus.rx_valid, 1);
      bus.tx_data  = 32'h600D_F00D;
      bus.tx_valid = 1'b1;
      n0 = n_start;
      repeat (20) @(negedge clk);
      check_int("bp_no_start", n_start - n0, 0);
      check("bp_rx_held", bus.rx_data, 32'h0BAD_CAFE);
      check("bp_cs_high", cs_n, 1);
      ack();
      send(32'h600D_F00D, acc);
      wait_rx(d);
      check("bp_second_rx", d, 32'h600D_F00D);
      ack();
      wait_idle();

      // Shifter never returns ready: timeout.
      stuck = 1'b1;
      f0 = frames_done;
      l0 = rx_log.size();
      send(32'h5555_AAAA, acc);
      wait_frame(f0);
      check_int("to_err_latency", err_cyc - acc, ERR_LAT);
      check_int("to_cs_low", cs_low_len, CS_LOW_TO);
      check("to_rx_valid", bus.rx_valid, 0);
      check_int("to_no_capture", rx_log.size() - l0, 0);
      repeat (5) @(negedge clk);
      check("to_err_sticky", bus.xfer_err, 1);
      stuck = 1'b0;
      wait_idle();

      // Reset mid-XFER with xfer_err still set.
      send(32'h1357_9BDF, acc);
      repeat (10) @(negedge clk);
      check("mid_cs_low_before_rst", cs_n, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_cs_n", cs_n, 1);
      check("mid_rst_tx_ready", bus.tx_ready, 1);
      check("mid_rst_rx_valid", bus.rx_valid, 0);
      check("mid_rst_xfer_err", bus.xfer_err, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n0 = n_start;
      r0 = n_rxstart;
      repeat (60) @(negedge clk);
      check_int("mid_no_tx_refire", n_start - n0, 0);
      check_int("mid_no_rx_refire", n_rxstart - r0, 0);
      check("mid_cs_stays_high", cs_n, 1);

      // Timeout while err_clr held: set wins that cycle, clear takes it next.
      stuck       = 1'b1;
      bus.err_clr = 1'b1;
      f0 = frames_done;
      send(32'h0F0F_0F0F, acc);
      wait_frame(f0);
      check_int("clr_set_wins", err_cyc - acc, ERR_LAT);
      check("clr_cleared", bus.xfer_err, 0);
      bus.err_clr = 1'b0;
      stuck       = 1'b0;
      wait_idle();

      // Randomized frames against a queue of sent words.
      for (int i = 0; i < 12; i++) begin
         logic [W-1:0] w;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         w = $urandom;
         exp_q.push_back(w);
         f0 = frames_done;
         send(w, acc);
         wait_rx(d);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         ack();
         check("rand_rx_data", d, exp_q.pop_front());
         check_int("rand_start_lat", start_cyc - acc, LAT);
         wait_frame(f0);
         check_int("rand_cs_low", cs_low_len, CS_LOW_OK);
         wait_idle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
